alu_out_stage: RTL and testbench

Registered output stage that sits directly downstream of the 8-bit ALU datapath (adder, incrementer and the other function units). It captures each result with its carry-out and operation tag, derives status flags, and buffers up to DEPTH results behind a valid/ready handshake. It also tracks carry events in a sticky bit and a saturating counter. This decouples the combinational ALU from its consumer.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_out_fifo.sv | 58 +++++
 rtl/alu_out_stage.sv | 95 +++++++++
 tb/tb_alu_out_stage.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU output stage: default widths, flag layout
// and carry statistics constants.
package alu_pkg;

   localparam int WIDTH = 8;
   localparam int TAGW  = 3;

   localparam int NFLAGS = 4;
   localparam int FLG_C  = 3;
   localparam int FLG_Z  = 2;
   localparam int FLG_N  = 1;
   localparam int FLG_P  = 0;

   typedef logic [NFLAGS-1:0] flags_t;

   localparam int               CNT_W   = 8;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/alu_out_fifo.sv
// Generic circular buffer with registered level.
// Storage is cleared on reset so the head output is always defined.
module alu_out_fifo #(
   parameter int DW    = 15,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [DW-1:0]            wdata,
   output logic [DW-1:0]            rdata,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // DEPTH is a power of two, so pointer wrap is plain binary overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/alu_out_stage.sv
// Registered output stage for the ALU: flag generation at capture, buffered
// valid/ready hand-off, and carry statistics.
module alu_out_stage #(
   parameter int WIDTH = alu_pkg::WIDTH,
   parameter int DEPTH = 2,
   parameter int TAGW  = alu_pkg::TAGW
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       in_res,
   input  logic                   in_cout,
   input  logic [TAGW-1:0]        in_tag,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out_res,
   output logic [TAGW-1:0]        out_tag,
   output logic [3:0]             out_flags,
   output logic                   carry_sticky,
   output logic [7:0]             carry_cnt,
   input  logic                   clr_stat,
   output logic [$clog2(DEPTH):0] level
);

   import alu_pkg::*;

   localparam int EW = WIDTH + TAGW + NFLAGS;

   typedef struct packed {
      logic [WIDTH-1:0] res;
      logic [TAGW-1:0]  tag;
      flags_t           flags;
   } entry_t;

   entry_t in_entry;
   entry_t head;
   flags_t in_flags;
   logic   full;
   logic   empty;
   logic   push;
   logic   pop;
   logic   count_carry;

   always_comb begin
      in_flags        = '0;
      in_flags[FLG_C] = in_cout;
      in_flags[FLG_Z] = (in_res == '0);
      in_flags[FLG_N] = in_res[WIDTH-1];
      in_flags[FLG_P] = ^in_res;
   end

   assign in_entry    = '{res: in_res, tag: in_tag, flags: in_flags};
   assign in_ready    = !full;
   assign out_valid   = !empty;
   assign push        = in_valid && in_ready;
   assign pop         = out_valid && out_ready;
   assign count_carry = push && in_cout;

   alu_out_fifo #(
      .DW    (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .wdata (in_entry),
      .rdata (head),
      .level (level),
      .full  (full),
      .empty (empty)
   );

   assign out_res   = head.res;
   assign out_tag   = head.tag;
   assign out_flags = head.flags;

   // A clear wins over the old count, but a carry pushed in the same cycle still counts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         carry_sticky <= 1'b0;
         carry_cnt    <= '0;
      end else if (clr_stat) begin
         carry_sticky <= count_carry;
         carry_cnt    <= count_carry ? CNT_W'(1) : '0;
      end else if (count_carry) begin
         carry_sticky <= 1'b1;
         if (carry_cnt != CNT_MAX) begin
            carry_cnt <= carry_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_alu_out_stage.sv
// Self-checking bench for alu_out_stage: queue-based reference model checked
// every cycle, plus directed vectors with hand-computed literals.
module tb_alu_out_stage;

   localparam int DEPTH = 2;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_res;
   logic       in_cout;
   logic [2:0] in_tag;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_res;
   logic [2:0] out_tag;
   logic [3:0] out_flags;
   logic       carry_sticky;
   logic [7:0] carry_cnt;
   logic       clr_stat;
   logic [1:0] level;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [7:0] res;
      logic [2:0] tag;
      logic [3:0] flags;
   } exp_t;

   exp_t model_q[$];
   int   model_cnt;
   bit   model_sticky;

   alu_out_stage #(.WIDTH(8), .DEPTH(DEPTH), .TAGW(3)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_res       (in_res),
      .in_cout      (in_cout),
      .in_tag       (in_tag),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_res      (out_res),
      .out_tag      (out_tag),
      .out_flags    (out_flags),
      .carry_sticky (carry_sticky),
      .carry_cnt    (carry_cnt),
      .clr_stat     (clr_stat),
      .level        (level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] expectFlags(input logic [7:0] r, input logic c);
      logic [3:0] f;
      f[3] = c;
      f[2] = (r == 8'd0);
      f[1] = (r >= 8'h80);
      f[0] = ($countones(r) % 2) == 1;
      return f;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Inputs are set just after a falling edge and captured at the next rising edge.
   task automatic applyStimulus(input logic v, input logic [7:0] r, input logic c,
                                input logic [2:0] t, input logic rdy, input logic clr);
      in_valid  = v;
      in_res    = r;
      in_cout   = c;
      in_tag    = t;
      out_ready = rdy;
      clr_stat  = clr;
      @(negedge clk);
   endtask

   // Reference model: a bounded queue plus plain counters.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         model_q.delete();
         model_cnt    = 0;
         model_sticky = 0;
      end else begin
         bit do_push;
         bit do_pop;
         do_push = in_valid && (model_q.size() < DEPTH);
         do_pop  = out_ready && (model_q.size() > 0);
         if (clr_stat) begin
            model_cnt    = 0;
            model_sticky = 0;
         end
         if (do_push && in_cout) begin
            model_sticky = 1;
            if (model_cnt < 255) model_cnt++;
         end
         if (do_pop) void'(model_q.pop_front());
         if (do_push) model_q.push_back('{res: in_res, tag: in_tag, flags: expectFlags(in_res, in_cout)});
      end
   end

   always @(negedge clk) begin
      checkOutput("m_out_valid", 32'(out_valid), 32'(model_q.size() != 0));
      checkOutput("m_in_ready", 32'(in_ready), 32'(model_q.size() != DEPTH));
      checkOutput("m_level", 32'(level), 32'(model_q.size()));
      checkOutput("m_sticky", 32'(carry_sticky), 32'(model_sticky));
      checkOutput("m_cnt", 32'(carry_cnt), 32'(model_cnt));
      if (model_q.size() != 0) begin
         checkOutput("m_out_res", 32'(out_res), 32'(model_q[0].res));
         checkOutput("m_out_tag", 32'(out_tag), 32'(model_q[0].tag));
         checkOutput("m_out_flags", 32'(out_flags), 32'(model_q[0].flags));
      end
   end

   logic [7:0] stream_vals [6];

   initial begin
      stream_vals = '{8'h01, 8'hFF, 8'h00, 8'h3C, 8'h80, 8'hA5};
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_res    = '0;
      in_cout   = 1'b0;
      in_tag    = '0;
      out_ready = 1'b0;
      clr_stat  = 1'b0;
      @(negedge clk);
      @(negedge clk);

      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("rst_level", 32'(level), 32'd0);
      checkOutput("rst_cnt", 32'(carry_cnt), 32'd0);
      checkOutput("rst_sticky", 32'(carry_sticky), 32'd0);
      checkOutput("rst_out_res", 32'(out_res), 32'd0);
      checkOutput("rst_out_tag", 32'(out_tag), 32'd0);
      checkOutput("rst_out_flags", 32'(out_flags), 32'd0);
      rst_n = 1'b1;

      $display("[TB] fill buffer without consumer");
      applyStimulus(1'b1, 8'h00, 1'b1, 3'd3, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h80, 1'b0, 3'd5, 1'b0, 1'b0);
      checkOutput("fill_level", 32'(level), 32'd2);
      checkOutput("fill_in_ready", 32'(in_ready), 32'd0);
      checkOutput("fill_flags0", 32'(out_flags), 32'b1100);
      checkOutput("fill_tag0", 32'(out_tag), 32'd3);
      checkOutput("fill_cnt", 32'(carry_cnt), 32'd1);

      $display("[TB] full buffer with same-cycle pop refuses push");
      applyStimulus(1'b1, 8'h55, 1'b0, 3'd1, 1'b1, 1'b0);
      checkOutput("full_pop_level", 32'(level), 32'd1);
      checkOutput("full_pop_res", 32'(out_res), 32'h80);
      checkOutput("full_pop_flags", 32'(out_flags), 32'b0011);
      checkOutput("full_pop_tag", 32'(out_tag), 32'd5);
      applyStimulus(1'b1, 8'h7F, 1'b1, 3'd2, 1'b1, 1'b0);
      checkOutput("pushpop_level", 32'(level), 32'd1);
      checkOutput("pushpop_res", 32'(out_res), 32'h7F);
      checkOutput("pushpop_flags", 32'(out_flags), 32'b1001);
      checkOutput("pushpop_cnt", 32'(carry_cnt), 32'd2);
      applyStimulus(1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0);
      checkOutput("drain_level", 32'(level), 32'd0);

      $display("[TB] asynchronous reset mid-transfer");
      applyStimulus(1'b1, 8'h11, 1'b1, 3'd4, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h22, 1'b0, 3'd6, 1'b0, 1'b0);
      checkOutput("pre_rst_level", 32'(level), 32'd2);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_level", 32'(level), 32'd0);
      checkOutput("async_out_valid", 32'(out_valid), 32'd0);
      checkOutput("async_in_ready", 32'(in_ready), 32'd1);
      checkOutput("async_cnt", 32'(carry_cnt), 32'd0);
      checkOutput("async_sticky", 32'(carry_sticky), 32'd0);
      checkOutput("async_out_res", 32'(out_res), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] streaming six results");
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, stream_vals[i], i[0], 3'(i), 1'b1, 1'b0);
         checkOutput("stream_res", 32'(out_res), 32'(stream_vals[i]));
         checkOutput("stream_level", 32'(level), 32'd1);
      end
      applyStimulus(1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0);
      checkOutput("stream_cnt", 32'(carry_cnt), 32'd3);

      $display("[TB] carry counter saturation and clear");
      for (int i = 0; i < 256; i++) begin
         applyStimulus(1'b1, 8'(i), 1'b1, 3'(i), 1'b1, 1'b0);
      end
      checkOutput("sat_cnt", 32'(carry_cnt), 32'd255);
      checkOutput("sat_sticky", 32'(carry_sticky), 32'd1);
      applyStimulus(1'b1, 8'h42, 1'b1, 3'd7, 1'b1, 1'b1);
      checkOutput("clr_push_cnt", 32'(carry_cnt), 32'd1);
      checkOutput("clr_push_sticky", 32'(carry_sticky), 32'd1);
      applyStimulus(1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b1);
      checkOutput("clr_cnt", 32'(carry_cnt), 32'd0);
      checkOutput("clr_sticky", 32'(carry_sticky), 32'd0);
      checkOutput("final_level", 32'(level), 32'd0);
      applyStimulus(1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
